// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, latency classes and FSM states for the multiply/divide unit.
// MULDIV_MADD_EN adds the multiply-accumulate opcodes 7-10.
package muldiv_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    LAT_NONE,
    LAT_MOVE,
    LAT_MUL,
    LAT_DIV
  } lat_class_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // Unknown (and disabled) opcodes fall into LAT_NONE and are ignored.
  function automatic lat_class_e lat_class(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: lat_class = LAT_MUL;
      OP_DIV, OP_DIVU:   lat_class = LAT_DIV;
      OP_MTHI, OP_MTLO:  lat_class = LAT_MOVE;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: lat_class = LAT_MUL;
`endif
      default:           lat_class = LAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_compute.sv
// Combinational multiply/divide datapath including divide edge cases.
// MULDIV_MADD_EN adds accumulate/subtract against the current {hi,lo}.
module muldiv_compute
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             valid
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    sgn;
  logic [W2-1:0]           ext_a;
  logic [W2-1:0]           ext_b;
  logic [W2-1:0]           prod;
  logic signed [WIDTH-1:0] sq;
  logic signed [WIDTH-1:0] sr;
  logic [WIDTH-1:0]        uq;
  logic [WIDTH-1:0]        ur;

  // Product of 2W-bit extended operands is exact modulo 2^(2W) for both signednesses.
  always_comb begin
    sgn = (op == OP_MULT) || (op == OP_DIV);
`ifdef MULDIV_MADD_EN
    sgn = sgn || (op == OP_MADD) || (op == OP_MSUB);
`endif
    ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = ext_a * ext_b;
    sq    = $signed(a) / $signed(b);
    sr    = $signed(a) % $signed(b);
    uq    = a / b;
    ur    = a % b;
  end

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    valid  = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        {res_hi, res_lo} = prod;
        valid            = 1'b1;
      end
      OP_DIV: begin
        if (b != '0) begin
          valid = 1'b1;
          if ((a == MIN_VAL) && (&b)) begin
            res_lo = MIN_VAL;
            res_hi = '0;
          end else begin
            res_lo = sq;
            res_hi = sr;
          end
        end
      end
      OP_DIVU: begin
        if (b != '0) begin
          valid  = 1'b1;
          res_lo = uq;
          res_hi = ur;
        end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU: begin
        {res_hi, res_lo} = {hi, lo} + prod;
        valid            = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {res_hi, res_lo} = {hi, lo} - prod;
        valid            = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy/latency sequencing.
// MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU (multiply latency).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  input  logic             cancel,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_valid;
  lat_class_e       cls;

  muldiv_compute #(.WIDTH(WIDTH)) u_compute (
    .op     (op),
    .a      (A),
    .b      (B),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .valid  (res_valid)
  );

  assign cls  = lat_class(op);
  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  // Accept only in IDLE without cancel; an invalid result (divide by zero) keeps HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cancel) begin
          case (cls)
            LAT_MOVE: begin
              if (op == OP_MTHI) hi_d = A;
              else               lo_d = A;
            end
            LAT_MUL, LAT_DIV: begin
              start   = 1'b1;
              sh_hi_d = res_valid ? res_hi : hi_q;
              sh_lo_d = res_valid ? res_lo : lo_q;
              cnt_d   = (cls == LAT_MUL) ? MUL_LOAD : DIV_LOAD;
              busy_d  = 1'b1;
              state_d = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits in the E stage. Accepts one op per idle cycle and holds `busy` while the op executes.
- Commits HI/LO after a configurable latency. The hazard unit stalls mf/mt/mul/div ops while `busy` or `start` is high.
- Generalises the fixed 32-bit unit: configurable width and latencies, a cancel input for exception flush, and defined divide edge cases.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>=2).
- MUL_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand rs.
- B  input  WIDTH  operand rt.
- op  input  4  operation code (encodings in package); 0 = none.
- cancel  input  1  exception/flush; blocks acceptance of op this cycle.
- start  output  1  combinational; high when a mul/div op is accepted this cycle.
- busy  output  1  registered; high while a mul/div is executing.
- HI  output  WIDTH  architectural HI.
- LO  output  WIDTH  architectural LO.

Behaviour:
- Reset, checked first every edge: HI=0, LO=0, busy=0, counter=0, shadow results=0. Any in-flight op is discarded.
- Accept condition: busy==0 && cancel==0 && op!=NONE. Ops presented while busy or cancelled are ignored with no side effect.
- start = accept && op in {MULT, MULTU, DIV, DIVU, and accumulate ops when enabled}. start is 0 for mthi/mtlo.
- States:
  - IDLE: on an accepted mul/div at edge t0, latch the full result into shadow_hi/shadow_lo, load counter = N-1, go to RUN.
  - RUN: busy=1; counter decrements each edge. At the edge where counter==0: HI/LO <= shadow, return to IDLE.
  - Timing: busy is high for exactly N cycles (t0+1 .. t0+N). New HI/LO are visible in the first cycle busy is low.
- MTHI/MTLO (IDLE only): HI or LO <= A at the accepting edge; no busy. Simultaneous reset wins.
- Multiply:
  - Full 2*WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
  - MULT sign-extends both operands; MULTU zero-extends them.
- Divide:
  - LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - B==0: HI/LO unchanged at commit; busy still lasts DIV_CYCLES.
  - Signed MIN/-1: LO = MIN, HI = 0.
- cancel only gates acceptance. It never aborts a RUN-state op, because that op belongs to an older, committed instruction.
- Unknown opcodes behave as NONE.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- When defined, the unit adds MADD=7, MADDU=8, MSUB=9, MSUBU=10:
  - {HI,LO} <= {HI,LO} ± product, using signed or unsigned product extension respectively.
  - Accumulation wraps modulo 2^(2*WIDTH).
  - Uses MUL_CYCLES. The {HI,LO} base is sampled at acceptance.
- When not defined, opcodes 7-10 are treated as NONE: no start, no busy.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, plus 7-10 when enabled.
  - a function returning the latency class of an opcode.
- Sub-module muldiv_compute is natural: purely combinational, taking (op, A, B, HI, LO) and returning {res_hi, res_lo, valid}. It isolates the arithmetic and edge cases from the counter/FSM in muldiv_unit.

Test Plan:
- mult, A=233, B=2, op held for one cycle:
  - start=1 that cycle; busy high exactly 5 cycles.
  - Then HI=0x00000000, LO=0x000001D2. HI/LO stay unchanged while busy.
- mult A=-3 (0xFFFFFFFD), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu with the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- div A=-7, B=2 -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=0xFFFFFFFF, B=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F.
- Divide edge cases:
  - div by B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy 10 cycles; HI/LO unchanged.
  - div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Hazards and reset:
  - mthi with A=0xAA while busy -> ignored; HI equals the mul result afterwards.
  - op=MULT with cancel=1 -> start=0, busy stays 0.
  - reset asserted at busy cycle 3 -> next cycle busy=0, HI=LO=0, and no later commit occurs.
